// File: rtl/mlp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : mlp_pkg                                                         |
// | Purpose  : Types and constants shared by the MLP datapath blocks:          |
// |            activation buffer FSM states, activation width and the          |
// |            unsigned saturation limit applied at requantisation.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mlp_pkg;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      DRAIN   = 1'b1
   } state_t;

   localparam int ACT_W   = 8;
   localparam int SAT_MAX = 255;

endpackage
`default_nettype wire

// File: rtl/neuron_activation_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : neuron_activation_buffer_if                                    |
// | Purpose   : Handshake bundle of the activation buffer.                     |
// |   clear      : synchronous abort of the current layer                      |
// |   in_valid   : neuron ready pulse, in_data (N-bit signed) valid            |
// |   in_ready   : buffer accepts a result this cycle                          |
// |   out_valid  : out_data holds a buffered 8-bit activation                  |
// |   out_ready  : consumer takes out_data this cycle                          |
// |   out_last   : final value of the layer                                    |
// |   layer_done : one-cycle pulse after the final value is consumed           |
// |   ovf        : sticky, a result arrived while in_ready was low             |
// | Modports : master (producer/consumer side), slave (buffer side)            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface neuron_activation_buffer_if #(
   parameter int N = 18
);
   logic         clear;
   logic         in_valid;
   logic [N-1:0] in_data;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic         out_last;
   logic         layer_done;
   logic         ovf;

   modport master (
      output clear, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, layer_done, ovf
   );

   modport slave (
      input  clear, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, layer_done, ovf
   );
endinterface
`default_nettype wire

// File: rtl/relu_requant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : relu_requant                                                    |
// | Purpose  : Combinational ReLU, right shift by SHIFT and unsigned           |
// |            saturation of a signed N-bit accumulation to ACT_W bits.        |
// | Ports    : i_data (N-bit signed) -> o_act (ACT_W-bit unsigned)             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module relu_requant
   import mlp_pkg::*;
#(
   parameter int N     = 18,
   parameter int SHIFT = 0
) (
   input  wire logic [N-1:0]     i_data,
   output logic      [ACT_W-1:0] o_act
);

   logic [N-1:0] w_shifted;

   // After the sign test the value is non-negative, so a logical shift
   // equals the arithmetic one.
   always_comb begin
      w_shifted = i_data >> SHIFT;
      if (i_data[N-1]) begin
         o_act = '0;
      end else if (w_shifted > N'(SAT_MAX)) begin
         o_act = ACT_W'(SAT_MAX);
      end else begin
         o_act = w_shifted[ACT_W-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/neuron_activation_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : neuron_activation_buffer                                        |
// | Purpose  : Captures K neuron results, activates them (ReLU, shift,         |
// |            saturate to 8 bits) and streams them to the next layer over     |
// |            a valid/ready handshake.                                        |
// | Ports    : clk   - rising-edge clock                                       |
// |            rst_n - asynchronous active-low reset                           |
// |            bus   - neuron_activation_buffer_if.slave handshake bundle      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module neuron_activation_buffer
   import mlp_pkg::*;
#(
   parameter int N     = 18,
   parameter int K     = 4,
   parameter int SHIFT = 0
) (
   input wire logic clk,
   input wire logic rst_n,
   neuron_activation_buffer_if.slave bus
);

   localparam int CNT_W = $clog2(K);
   localparam logic [CNT_W-1:0] c_last = CNT_W'(K - 1);

   state_t            r_state;
   state_t            w_next_state;
   logic [CNT_W-1:0]  r_wr_cnt;
   logic [CNT_W-1:0]  r_rd_cnt;
   logic [ACT_W-1:0]  r_buf [K];
   logic              r_layer_done;
   logic              r_ovf;
   logic [ACT_W-1:0]  w_act;
   logic              w_capture;
   logic              w_transfer;

   relu_requant #(
      .N     (N),
      .SHIFT (SHIFT)
   ) u_relu_requant (
      .i_data (bus.in_data),
      .o_act  (w_act)
   );

   // clear overrides both a capture and a transfer in the same cycle.
   assign w_capture  = (r_state == COLLECT) && bus.in_valid && !bus.clear;
   assign w_transfer = (r_state == DRAIN) && bus.out_ready && !bus.clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= COLLECT;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (bus.clear) begin
         w_next_state = COLLECT;
      end else if (w_capture && (r_wr_cnt == c_last)) begin
         w_next_state = DRAIN;
      end else if (w_transfer && (r_rd_cnt == c_last)) begin
         w_next_state = COLLECT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_cnt     <= '0;
         r_rd_cnt     <= '0;
         r_layer_done <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         r_layer_done <= 1'b0;
         // A result offered while not accepting is lost; clear does not hide it.
         if (bus.in_valid && (r_state == DRAIN)) begin
            r_ovf <= 1'b1;
         end
         if (bus.clear) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
         end else begin
            if (w_capture) begin
               r_wr_cnt <= (r_wr_cnt == c_last) ? '0 : r_wr_cnt + 1'b1;
            end
            if (w_transfer) begin
               if (r_rd_cnt == c_last) begin
                  r_rd_cnt     <= '0;
                  r_layer_done <= 1'b1;
               end else begin
                  r_rd_cnt <= r_rd_cnt + 1'b1;
               end
            end
         end
      end
   end

   // Storage only; contents are masked whenever out_valid is low.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_buf[r_wr_cnt] <= w_act;
      end
   end

   assign bus.in_ready   = (r_state == COLLECT);
   assign bus.out_valid  = (r_state == DRAIN);
   assign bus.out_data   = (r_state == DRAIN) ? r_buf[r_rd_cnt] : '0;
   assign bus.out_last   = (r_state == DRAIN) && (r_rd_cnt == c_last);
   assign bus.layer_done = r_layer_done;
   assign bus.ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_neuron_activation_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_neuron_activation_buffer                                     |
// | Purpose  : Self-checking bench for neuron_activation_buffer. Two           |
// |            instances (SHIFT=0 and SHIFT=2); expected activations are      |
// |            queued when a layer is driven and popped on every transfer.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_neuron_activation_buffer;

   typedef struct packed {
      logic [7:0] d;
      logic       last;
   } exp_t;

   logic clk;
   logic rst_n;
   int   passed;
   int   total;
   exp_t q0[$];
   exp_t q1[$];

   neuron_activation_buffer_if #(.N(18)) bus0 ();
   neuron_activation_buffer_if #(.N(18)) bus1 ();

   neuron_activation_buffer #(.N(18), .K(4), .SHIFT(0)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.slave)
   );

   neuron_activation_buffer #(.N(18), .K(4), .SHIFT(2)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transfer monitors: sampled on the falling edge, half a cycle from the
   // edge that performs the handshake.
   always @(negedge clk) begin
      if (rst_n && bus0.out_valid && bus0.out_ready) begin
         exp_t e;
         total++;
         if (q0.size() == 0) begin
            $display("FAIL out0_unexpected: got data %0d last %0b, required no transfer",
                     bus0.out_data, bus0.out_last);
         end else begin
            e = q0.pop_front();
            if (bus0.out_data !== e.d || bus0.out_last !== e.last)
               $display("FAIL out0_data: got data %0d last %0b, required data %0d last %0b",
                        bus0.out_data, bus0.out_last, e.d, e.last);
            else
               passed++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus1.out_valid && bus1.out_ready) begin
         exp_t e;
         total++;
         if (q1.size() == 0) begin
            $display("FAIL out1_unexpected: got data %0d last %0b, required no transfer",
                     bus1.out_data, bus1.out_last);
         end else begin
            e = q1.pop_front();
            if (bus1.out_data !== e.d || bus1.out_last !== e.last)
               $display("FAIL out1_data: got data %0d last %0b, required data %0d last %0b",
                        bus1.out_data, bus1.out_last, e.d, e.last);
            else
               passed++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send0(input int v);
      logic [31:0] w;
      w = v;
      bus0.in_valid = 1'b1;
      bus0.in_data  = w[17:0];
      tick();
      bus0.in_valid = 1'b0;
   endtask

   task automatic send1(input int v);
      logic [31:0] w;
      w = v;
      bus1.in_valid = 1'b1;
      bus1.in_data  = w[17:0];
      tick();
      bus1.in_valid = 1'b0;
   endtask

   task automatic push0(input int d, input bit last);
      exp_t e;
      e.d    = d[7:0];
      e.last = last;
      q0.push_back(e);
   endtask

   // Counts cycles until layer_done is seen, bounded at 20.
   task automatic wait_done0(output int n);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n++;
         if (bus0.layer_done === 1'b1) break;
         if (i == 19) n = 99;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus0.clear = 1'b0; bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
      bus1.clear = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
      repeat (2) tick();
      total++;
      if ({bus0.in_ready, bus0.out_valid, bus0.out_data, bus0.out_last, bus0.layer_done, bus0.ovf}
          !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0})
         $display("FAIL reset_state: got rdy %b vld %b data %0d last %b done %b ovf %b, required 1 0 0 0 0 0",
                  bus0.in_ready, bus0.out_valid, bus0.out_data, bus0.out_last, bus0.layer_done, bus0.ovf);
      else
         passed++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int n;
      bus0.out_ready = 1'b1;
      push0(170, 0); push0(0, 0); push0(255, 0); push0(255, 1);
      send0(170); send0(-5); send0(300); send0(255);
      total++;
      if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'd170 || bus0.in_ready !== 1'b0)
         $display("FAIL basic_latency: got vld %b data %0d rdy %b, required 1 170 0",
                  bus0.out_valid, bus0.out_data, bus0.in_ready);
      else
         passed++;
      wait_done0(n);
      total++;
      if (n !== 4 || bus0.in_ready !== 1'b1)
         $display("FAIL basic_done: got cycles %0d rdy %b, required 4 1", n, bus0.in_ready);
      else
         passed++;
      tick();
      total++;
      if (bus0.layer_done !== 1'b0 || q0.size() !== 0)
         $display("FAIL basic_pulse: got done %b pending %0d, required 0 0",
                  bus0.layer_done, q0.size());
      else
         passed++;
   endtask

   task automatic test_shift2();
      exp_t e;
      int   n;
      int   exp_d [4] = '{42, 255, 0, 0};
      bus1.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e.d    = exp_d[i][7:0];
         e.last = (i == 3);
         q1.push_back(e);
      end
      send1(170); send1(1023); send1(3); send1(-1);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n++;
         if (bus1.layer_done === 1'b1) break;
         if (i == 19) n = 99;
      end
      total++;
      if (n !== 4 || q1.size() !== 0)
         $display("FAIL shift2_done: got cycles %0d pending %0d, required 4 0", n, q1.size());
      else
         passed++;
   endtask

   task automatic test_back_pressure();
      int n;
      bus0.out_ready = 1'b0;
      push0(170, 0); push0(0, 0); push0(255, 0); push0(255, 1);
      send0(170); send0(-5); send0(300); send0(255);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'd170 || bus0.out_last !== 1'b0)
            $display("FAIL bp_hold: cycle %0d got vld %b data %0d last %b, required 1 170 0",
                     i, bus0.out_valid, bus0.out_data, bus0.out_last);
         else
            passed++;
         if (i < 2) tick();
      end
      bus0.out_ready = 1'b1;
      wait_done0(n);
      total++;
      if (n !== 4 || q0.size() !== 0)
         $display("FAIL bp_done: got cycles %0d pending %0d, required 4 0", n, q0.size());
      else
         passed++;
   endtask

   task automatic test_overrun();
      int n;
      bus0.out_ready = 1'b0;
      push0(5, 0); push0(6, 0); push0(7, 0); push0(8, 1);
      send0(5); send0(6); send0(7); send0(8);
      send0(99);
      total++;
      if (bus0.ovf !== 1'b1 || bus0.in_ready !== 1'b0 || bus0.out_data !== 8'd5)
         $display("FAIL ovf_set: got ovf %b rdy %b data %0d, required 1 0 5",
                  bus0.ovf, bus0.in_ready, bus0.out_data);
      else
         passed++;
      bus0.out_ready = 1'b1;
      wait_done0(n);
      total++;
      if (n !== 4 || q0.size() !== 0 || bus0.ovf !== 1'b1)
         $display("FAIL ovf_drain: got cycles %0d pending %0d ovf %b, required 4 0 1",
                  n, q0.size(), bus0.ovf);
      else
         passed++;
   endtask

   task automatic test_clear();
      int n;
      bus0.out_ready = 1'b1;
      send0(11); send0(12);
      bus0.clear = 1'b1;
      send0(13);
      bus0.clear = 1'b0;
      total++;
      if (bus0.ovf !== 1'b1 || bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1)
         $display("FAIL clear_state: got ovf %b vld %b rdy %b, required 1 0 1",
                  bus0.ovf, bus0.out_valid, bus0.in_ready);
      else
         passed++;
      push0(1, 0); push0(2, 0); push0(3, 0); push0(4, 1);
      send0(1);
      send0(2);
      send0(3);
      total++;
      if (bus0.out_valid !== 1'b0)
         $display("FAIL clear_count: got vld %b after 3 captures, required 0", bus0.out_valid);
      else
         passed++;
      send0(4);
      wait_done0(n);
      total++;
      if (n !== 4 || q0.size() !== 0)
         $display("FAIL clear_done: got cycles %0d pending %0d, required 4 0", n, q0.size());
      else
         passed++;
   endtask

   task automatic test_reset_mid();
      int n;
      bus0.out_ready = 1'b0;
      push0(50, 0);
      send0(50); send0(60); send0(70); send0(80);
      bus0.out_ready = 1'b1;
      tick();
      bus0.out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus0.in_ready, bus0.out_valid, bus0.out_data, bus0.out_last, bus0.layer_done, bus0.ovf}
          !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0} || q0.size() !== 0)
         $display("FAIL reset_mid: got rdy %b vld %b data %0d last %b done %b ovf %b pending %0d, required 1 0 0 0 0 0 0",
                  bus0.in_ready, bus0.out_valid, bus0.out_data, bus0.out_last,
                  bus0.layer_done, bus0.ovf, q0.size());
      else
         passed++;
      tick();
      rst_n = 1'b1;
      tick();
      bus0.out_ready = 1'b1;
      push0(10, 0); push0(20, 0); push0(30, 0); push0(40, 1);
      send0(10); send0(20); send0(30); send0(40);
      wait_done0(n);
      total++;
      if (n !== 4 || q0.size() !== 0)
         $display("FAIL reset_relayer: got cycles %0d pending %0d, required 4 0", n, q0.size());
      else
         passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_basic();
      test_shift2();
      test_back_pressure();
      test_overrun();
      test_clear();
      test_reset_mid();
      repeat (2) tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
